// File: rtl/rv32i_microcode_sequencer_if.sv
// rv32i_microcode_sequencer_if
//   Bundles the sequencer's data and control signals. Clock and reset are not
//   part of the bundle.
//   Optional counter port instret_o exists only when RV32I_SEQ_INSTRET_EN is defined.
//   master : the sequencer.
//            Inputs: instruction_i, stall_i, irq_i.
//            Outputs: microcode_addr_o, instr_done_o, irq_ack_o, illegal_o
//            and, when enabled, instret_o.
//   slave  : the surrounding core/ROM side, with the opposite directions.
interface rv32i_microcode_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic [31:0]       instruction_i;
    logic              stall_i;
    logic              irq_i;
    logic [ADDR_W-1:0] microcode_addr_o;
    logic              instr_done_o;
    logic              irq_ack_o;
    logic              illegal_o;
`ifdef RV32I_SEQ_INSTRET_EN
    logic [63:0]       instret_o;
`endif

    modport master (
        input  instruction_i, stall_i, irq_i,
        output microcode_addr_o, instr_done_o, irq_ack_o, illegal_o
`ifdef RV32I_SEQ_INSTRET_EN
        , output instret_o
`endif
    );

    modport slave (
        output instruction_i, stall_i, irq_i,
        input  microcode_addr_o, instr_done_o, irq_ack_o, illegal_o
`ifdef RV32I_SEQ_INSTRET_EN
        , input instret_o
`endif
    );
endinterface

// File: rtl/rv32i_microcode_sequencer.sv
// rv32i_microcode_sequencer
//   Produces the registered microcode ROM address for the RV32I microcoded core.
//   It runs the two-word fetch routine, then decodes the fetched instruction
//   into a routine start address and length, and steps through that routine.
//   After an instruction retires, it can enter the two-word interrupt pseudo-op.
//   An undecodable opcode halts the sequencer until reset.
//   Ports:
//     clk_i, reset_i : clock and synchronous active-high reset.
//     bus (master)   : instruction_i, stall_i, irq_i in;
//                      microcode_addr_o, instr_done_o, irq_ack_o, illegal_o out.
//   Optional: define RV32I_SEQ_INSTRET_EN to add the 64-bit retired-instruction
//   counter bus.instret_o.
module rv32i_microcode_sequencer #(
    parameter int ADDR_W = 5,
    parameter bit IRQ_EN = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    rv32i_microcode_sequencer_if.master      bus
);
    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_IRQ, ST_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              ack_q, ack_d;
    logic              illegal_q, illegal_d;
    logic [7:0]        dec;

    // Returns {valid, start[4:0], length-1[1:0]}. A result of zero means illegal.
    function automatic logic [7:0] decode(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [11:0] imm);
        logic [7:0] r;
        r = 8'h00;
        case (opc)
            7'b0000011: case (f3)
                3'b000, 3'b100: r = {1'b1, 5'h02, 2'd0};
                3'b001, 3'b101: r = {1'b1, 5'h03, 2'd0};
                3'b010:         r = {1'b1, 5'h04, 2'd1};
                default:        r = 8'h00;
            endcase
            7'b0001111: r = {1'b1, 5'h06, 2'd0};
            7'b0010011: r = {1'b1, 5'h07, 2'd0};
            7'b0010111: r = {1'b1, 5'h08, 2'd0};
            7'b0100011: case (f3)
                3'b000:  r = {1'b1, 5'h09, 2'd0};
                3'b001:  r = {1'b1, 5'h0A, 2'd0};
                3'b010:  r = {1'b1, 5'h0B, 2'd1};
                default: r = 8'h00;
            endcase
            7'b0110011: r = {1'b1, 5'h0D, 2'd0};
            7'b0110111: r = {1'b1, 5'h0E, 2'd0};
            7'b1100011: r = {1'b1, 5'h0F, 2'd0};
            7'b1100111: r = {1'b1, 5'h10, 2'd0};
            7'b1101111: r = {1'b1, 5'h11, 2'd0};
            // Only MRET is supported from the SYSTEM opcode space.
            7'b1110011: if (imm == 12'h302 && f3 == 3'b000) r = {1'b1, 5'h12, 2'd0};
            default:    r = 8'h00;
        endcase
        return r;
    endfunction

    // Register fields are not needed to choose a routine.
    logic unused_fields;
    assign unused_fields = ^{bus.instruction_i[19:15], bus.instruction_i[11:7]};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        ack_d     = 1'b0;
        illegal_d = illegal_q;
        dec       = decode(bus.instruction_i[6:0], bus.instruction_i[14:12],
                           bus.instruction_i[31:20]);
        // A stall freezes everything. Pulses drop to zero during the stall.
        if (!bus.stall_i) begin
            case (state_q)
                ST_FETCH: begin
                    if (addr_q == ADDR_W'(5'h00)) begin
                        addr_d = ADDR_W'(5'h01);
                    end else if (dec[7]) begin
                        addr_d  = ADDR_W'(dec[6:2]);
                        cnt_d   = dec[1:0];
                        state_d = ST_EXEC;
                    end else begin
                        addr_d    = ADDR_W'(5'h00);
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q != 2'd0) begin
                        addr_d = addr_q + ADDR_W'(1);
                        cnt_d  = cnt_q - 2'd1;
                    end else begin
                        done_d = 1'b1;
                        // The IRQ request is sampled only here, at instruction
                        // completion. As a result, there can be no back-to-back
                        // interrupt entry.
                        if (IRQ_EN && bus.irq_i) begin
                            addr_d  = ADDR_W'(5'h13);
                            ack_d   = 1'b1;
                            state_d = ST_IRQ;
                        end else begin
                            addr_d  = ADDR_W'(5'h00);
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_IRQ: begin
                    if (addr_q == ADDR_W'(5'h13)) begin
                        addr_d = ADDR_W'(5'h14);
                    end else begin
                        addr_d  = ADDR_W'(5'h00);
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    addr_d = ADDR_W'(5'h00);
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_FETCH;
            addr_q    <= '0;
            cnt_q     <= 2'd0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.microcode_addr_o = addr_q;
    assign bus.instr_done_o     = done_q;
    assign bus.irq_ack_o        = ack_q;
    assign bus.illegal_o        = illegal_q;

`ifdef RV32I_SEQ_INSTRET_EN
    // The counter steps on the same edge that raises instr_done_o. The
    // interrupt routine and HALT never raise instr_done_o, so they are not
    // counted.
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q + (done_d ? 64'd1 : 64'd0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) instret_q <= 64'd0;
        else         instret_q <= instret_d;
    end

    assign bus.instret_o = instret_q;
`endif
endmodule
